// File: rtl/uart_state_mux.sv
// Transmit framer for the board-to-board UART link.
// Snapshots the game state and sends it as five tagged 16-bit words.
module uart_state_mux #(
    parameter int FRAME_GAP = 1000,
    parameter int TIMEOUT   = 65535,
    parameter int NWORDS    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        conv16to8ready,
    input  logic        tx_done,
    input  logic [11:0] pl1_posx,
    input  logic [11:0] pl1_posy,
    input  logic [11:0] ball_posx,
    input  logic [11:0] ball_posy,
    input  logic [3:0]  pl1_score,
    input  logic [3:0]  pl2_score,
    input  logic        flag_point,
    input  logic        end_game,
    input  logic        reset_req,
    output logic [15:0] data,
    output logic        data_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam int GAP_W = $clog2(FRAME_GAP + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_DONE
    } state_t;

    state_t            state;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [2:0]        index;
    logic [11:0]       snap_pl1_posx;
    logic [11:0]       snap_pl1_posy;
    logic [11:0]       snap_ball_posx;
    logic [11:0]       snap_ball_posy;
    logic [11:0]       snap_status;
    logic              rst_pending;
    logic              req_seen;
    logic              data_live;
    logic [15:0]       word_mux;

    always_comb begin
        word_mux = 16'h0000;
        case (index)
            3'd0:    word_mux = {4'h1, snap_pl1_posx};
            3'd1:    word_mux = {4'h2, snap_pl1_posy};
            3'd2:    word_mux = {4'h3, snap_ball_posx};
            3'd3:    word_mux = {4'h4, snap_ball_posy};
            3'd4:    word_mux = {4'h5, snap_status};
            default: word_mux = 16'h0000;
        endcase
    end

    // Output stays zero until the first snapshot, then tracks the current word.
    assign data = data_live ? word_mux : 16'h0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            gap_cnt        <= '0;
            to_cnt         <= '0;
            index          <= 3'd0;
            snap_pl1_posx  <= 12'h000;
            snap_pl1_posy  <= 12'h000;
            snap_ball_posx <= 12'h000;
            snap_ball_posy <= 12'h000;
            snap_status    <= 12'h000;
            rst_pending    <= 1'b0;
            req_seen       <= 1'b0;
            data_live      <= 1'b0;
            data_valid     <= 1'b0;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            timeout_err <= 1'b0;
            if (reset_req) begin
                rst_pending <= 1'b1;
                req_seen    <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (gap_cnt == GAP_W'(FRAME_GAP - 1)) begin
                        gap_cnt <= '0;
                        state   <= LOAD;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    snap_pl1_posx  <= pl1_posx;
                    snap_pl1_posy  <= pl1_posy;
                    snap_ball_posx <= ball_posx;
                    snap_ball_posy <= ball_posy;
                    snap_status    <= {pl1_score, pl2_score, flag_point,
                                       end_game, rst_pending, 1'b0};
                    // Requests from here on belong to the following frame.
                    req_seen       <= reset_req;
                    index          <= 3'd0;
                    busy           <= 1'b1;
                    data_live      <= 1'b1;
                    state          <= SEND;
                end
                SEND: begin
                    if (conv16to8ready) begin
                        data_valid <= 1'b1;
                        to_cnt     <= '0;
                        state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // A tx_done in the strobe cycle belongs to an earlier word.
                    if (tx_done && !data_valid) begin
                        if (index == 3'(NWORDS - 1)) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                            if (snap_status[1] && !req_seen && !reset_req)
                                rst_pending <= 1'b0;
                        end else begin
                            index <= index + 1'b1;
                            state <= SEND;
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_state_mux.sv
// Bench for uart_state_mux: directed frame scenarios with randomized payloads,
// checked against a frame-level model of the link protocol.
module tb_uart_state_mux;

    localparam int FRAME_GAP = 4;
    localparam int TIMEOUT   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        conv16to8ready;
    logic        tx_done;
    logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
    logic [3:0]  pl1_score, pl2_score;
    logic        flag_point, end_game, reset_req;
    logic [15:0] data;
    logic        data_valid, busy, timeout_err;

    int errors = 0;
    int checks = 0;

    bit          model_pending;
    bit          snap_pend;
    bit          req_since_snap;
    logic [15:0] exp_words [5];

    uart_state_mux #(.FRAME_GAP(FRAME_GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .conv16to8ready(conv16to8ready), .tx_done(tx_done),
        .pl1_posx(pl1_posx), .pl1_posy(pl1_posy), .ball_posx(ball_posx),
        .ball_posy(ball_posy), .pl1_score(pl1_score), .pl2_score(pl2_score),
        .flag_point(flag_point), .end_game(end_game), .reset_req(reset_req),
        .data(data), .data_valid(data_valid), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        pl1_posx   = 12'($urandom_range(0, 4095));
        pl1_posy   = 12'($urandom_range(0, 4095));
        ball_posx  = 12'($urandom_range(0, 4095));
        ball_posy  = 12'($urandom_range(0, 4095));
        pl1_score  = 4'($urandom_range(0, 15));
        pl2_score  = 4'($urandom_range(0, 15));
        flag_point = 1'($urandom_range(0, 1));
        end_game   = 1'($urandom_range(0, 1));
    endtask

    // Expected frame is the input state at the moment the frame starts.
    task automatic build_expected();
        exp_words[0] = {4'h1, pl1_posx};
        exp_words[1] = {4'h2, pl1_posy};
        exp_words[2] = {4'h3, ball_posx};
        exp_words[3] = {4'h4, ball_posy};
        exp_words[4] = {4'h5, pl1_score, pl2_score, flag_point, end_game, model_pending, 1'b0};
        snap_pend      = model_pending;
        req_since_snap = 1'b0;
    endtask

    task automatic wait_frame_start(input int gap_ticks, input bit pulse_req);
        int n;
        n = 0;
        if (pulse_req) begin
            reset_req     = 1'b1;
            model_pending = 1'b1;
        end
        while (busy !== 1'b1 && n < gap_ticks + 4) begin
            tick();
            reset_req = 1'b0;
            n++;
        end
        reset_req = 1'b0;
        checkOutput("frame_gap", n, gap_ticks);
        build_expected();
        checkOutput("load_word", data, exp_words[0]);
    endtask

    task automatic run_frame(input bit long_stall, input int abort_word, input int rst_word,
                             input bit req_in_last, input int change_mode);
        int stall;
        int d;
        for (int w = 0; w < 5; w++) begin
            stall = long_stall && w == 0 ? 20 : $urandom_range(0, 3);
            conv16to8ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                tick();
                checkOutput("stall_dv", data_valid, 1'b0);
                checkOutput("stall_data", data, exp_words[w]);
            end
            conv16to8ready = 1'b1;
            tick();
            checkOutput("strobe", data_valid, 1'b1);
            checkOutput("word", data, exp_words[w]);
            conv16to8ready = 1'($urandom_range(0, 1));
            if (w == 0 && change_mode == 1) ball_posx = 12'd700;
            if (w == 0 && change_mode == 2) applyStimulus();

            if (w == abort_word) begin
                for (int k = 1; k < TIMEOUT; k++) begin
                    tick();
                    checkOutput("pre_timeout", {busy, timeout_err}, 2'b10);
                end
                tick();
                checkOutput("timeout_err", timeout_err, 1'b1);
                checkOutput("timeout_busy", busy, 1'b0);
                checkOutput("timeout_data", data, exp_words[w]);
                tick();
                checkOutput("timeout_pulse", timeout_err, 1'b0);
                return;
            end
            if (w == rst_word) begin
                rst = 1'b1;
                tick();
                checkOutput("midrst_out", {data, data_valid, busy, timeout_err}, 19'h0);
                tick();
                rst = 1'b0;
                model_pending = 1'b0;
                return;
            end

            // A tx_done landing in the strobe cycle must not complete the word.
            tx_done = 1'($urandom_range(0, 1));
            d = $urandom_range(2, 12);
            for (int k = 1; k <= d; k++) begin
                tick();
                tx_done   = 1'b0;
                reset_req = 1'b0;
                checkOutput("wait_state", {data_valid, busy}, 2'b01);
                checkOutput("wait_data", data, exp_words[w]);
                if (k == 1 && w == 4 && req_in_last) begin
                    reset_req      = 1'b1;
                    model_pending  = 1'b1;
                    req_since_snap = 1'b1;
                end
                if (k == d) tx_done = 1'b1;
            end
            tick();
            tx_done   = 1'b0;
            reset_req = 1'b0;
            if (w < 4) begin
                checkOutput("next_send", {data_valid, busy}, 2'b01);
            end else begin
                checkOutput("frame_end_busy", {data_valid, busy}, 2'b00);
                checkOutput("frame_end_data", data, exp_words[4]);
                if (snap_pend) model_pending = req_since_snap;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        conv16to8ready = 1'b0;
        tx_done = 1'b0;
        reset_req = 1'b0;
        model_pending = 1'b0;
        applyStimulus();
        tick(); tick(); tick();
        checkOutput("reset_out", {data, data_valid, busy, timeout_err}, 19'h0);

        pl1_posx = 12'd100; pl1_posy = 12'd600;
        ball_posx = 12'd512; ball_posy = 12'd300;
        pl1_score = 4'd3; pl2_score = 4'd7;
        flag_point = 1'b1; end_game = 1'b0;
        rst = 1'b0;
        wait_frame_start(FRAME_GAP + 1, 1'b1);
        run_frame(1'b0, -1, -1, 1'b0, 1);
        wait_frame_start(FRAME_GAP + 1, 1'b0);
        run_frame(1'b1, -1, -1, 1'b1, 2);
        wait_frame_start(FRAME_GAP + 1, 1'b0);
        run_frame(1'b0, 1, -1, 1'b0, 2);
        wait_frame_start(FRAME_GAP, 1'b0);
        run_frame(1'b0, -1, -1, 1'b0, 2);
        wait_frame_start(FRAME_GAP + 1, 1'b0);
        run_frame(1'b0, -1, 2, 1'b0, 2);
        wait_frame_start(FRAME_GAP + 1, 1'b0);
        for (int f = 0; f < 4; f++) begin
            run_frame(1'b0, -1, -1, 1'($urandom_range(0, 1)), 2);
            wait_frame_start(FRAME_GAP + 1, 1'($urandom_range(0, 1)));
        end
        run_frame(1'b0, -1, -1, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
